matrix_scan: RTL
================

// Module: matrix_scan
// PURPOSE
//  Scan controller for the 8x8 LED matrix. Sequences reads of the framebuffer BRAM
//  through its second (read-only) port, one word per row, and latches each word.
//  Drives one-hot row select and per-column PWM so each pixel has BPP-bit intensity.
//  Sits between the framebuffer BRAM (CPU writes it over wishbone) and the matrix pins.
// PARAMETERS
//  ROWS         8   rows scanned; row r is framebuffer word address r
//  COLS         8   columns per row
//  BPP          4   intensity bits per pixel; column c = mem_rdata[c*BPP +: BPP]
//  DATA_WIDTH   32  framebuffer word width; must equal COLS*BPP (elaboration $error)
//  ADDR_WIDTH   3   framebuffer address width; ROWS <= 2**ADDR_WIDTH ($error)
//  TICK_DIV     64  clocks per PWM slot, >= 1
//  BLANK_CYCLES 4   dark clocks between rows (anti-ghosting), >= 1
// PORTS
//  clk          in   1           system clock
//  reset        in   1           asynchronous reset, active high
//  enable       in   1           run scanning; sampled at row boundaries only
//  mem_rd       out  1           framebuffer read strobe, 1-cycle pulse
//  mem_addr     out  ADDR_WIDTH  framebuffer read address (= current row)
//  mem_rdata    in   DATA_WIDTH  read data, valid 1 cycle after mem_rd
//  row_sel      out  ROWS        one-hot row drive, active high
//  col_on       out  COLS        column drive, active high
//  frame_start  out  1           1-cycle pulse when row 0 is fetched
//  busy         out  1           high in every state except IDLE
// BEHAVIOUR
//  Clock is clk; reset is asynchronous and active-high.
//  Reset (async, any state): state=IDLE, row=0, row_buf=0, all counters 0.
//    All outputs 0 immediately, without waiting for a clock edge.
//  All outputs are registered. Row data is held in row_buf, so framebuffer writes
//    during SHOW do not affect the displayed row until that row's next fetch.
//  FSM states:
//   IDLE : outputs 0, row=0. enable=1 -> FETCH.
//   FETCH: 1 clk. mem_rd=1, mem_addr=row; frame_start=1 if row==0 -> LATCH.
//   LATCH: 1 clk. row_buf <= mem_rdata at end of cycle; pwm=0, tick=0 -> SHOW.
//   SHOW : row_sel=1<<row; col_on[c]=(pix[c] > pwm).
//          tick counts 0..TICK_DIV-1; on wrap pwm++.
//          After slot pwm=2**BPP-2 completes -> BLANK.
//          Duration is exactly (2**BPP-1)*TICK_DIV clocks.
//   BLANK: row_sel=0, col_on=0 for BLANK_CYCLES clocks.
//          Then row <= (row==ROWS-1) ? 0 : row+1.
//          Then enable=1 -> FETCH; enable=0 -> IDLE (row forced to 0).
//  Intensity: 0 = never lit; 2**BPP-1 = lit for every SHOW clock;
//    pixel value v is lit for exactly v*TICK_DIV clocks per row.
//  Row period = 2 + (2**BPP-1)*TICK_DIV + BLANK_CYCLES
//    (defaults: 966 clocks; frame = 7728 clocks).
//  row_sel and col_on never change in the same cycle as a row change:
//    BLANK always separates two rows.
//  enable falling mid-row: the current row completes SHOW and BLANK, then IDLE.
//    The scan is never truncated.
//  Re-enable from IDLE always restarts at row 0 with frame_start.
//  mem_rd is asserted only in FETCH, so there is at most one read per row period.
//    mem_addr holds its last value otherwise (0 after reset).
// TESTING
//  1 reset=1, enable=1, 200 clks -> row_sel=0, col_on=0, mem_rd=0, busy=0 throughout.
//  2 word0=32'h0000000F, others 0; enable=1
//    -> row_sel=8'h01 with col_on=8'h01 for exactly 960 clks, col_on=0 on all other rows.
//  3 word0=32'h76543210 -> in row 0, col_on[c] high for exactly c*64 clks (c=0..7).
//  4 enable held -> frame_start period 7728; row_sel 01,02,..,80,01; mem_addr 0..7 wrap.
//    >=4 all-zero clks between row changes.
//  5 enable dropped in SHOW of row 3 -> row 3 finishes, BLANK 4 clks, IDLE, no further mem_rd.
//    Re-enable -> mem_addr=0, frame_start pulse.
//  6 async reset pulse mid-SHOW between clock edges -> outputs 0 before next edge.
//    After release + enable, scan restarts at row 0.
//  7 overwrite word2 during SHOW of row 2 -> col_on unchanged until row 2 is next fetched.

Source files
------------

// File: rtl/matrix_scan_if.sv
// Framebuffer read-port bundle between the matrix scanner and the BRAM.
//   master (scanner): drives mem_rd / mem_addr, receives mem_rdata
//   slave  (BRAM)   : receives mem_rd / mem_addr, returns mem_rdata one clock later
interface matrix_scan_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_rd, output mem_addr, input  mem_rdata);
    modport slave  (input  mem_rd, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/matrix_scan.sv
// Scan controller for an LED matrix. Fetches one framebuffer word per row,
// holds it in row_buf, and drives one-hot rows with per-column PWM.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   enable       run scanning; only acted on at row boundaries
//   mem          framebuffer read port (matrix_scan_if.master)
//   row_sel      one-hot row drive
//   col_on       column drive
//   frame_start  1-cycle pulse when row 0 is fetched
//   busy         high whenever the scanner is not idle
module matrix_scan #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int BPP          = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 3,
    parameter int TICK_DIV     = 64,
    parameter int BLANK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    matrix_scan_if.master   mem,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_on,
    output logic            frame_start,
    output logic            busy
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [TW-1:0]         TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0]         BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [BPP-1:0]        PWM_LAST   = BPP'((2 ** BPP) - 2);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST   = ADDR_WIDTH'(ROWS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] SHOW  = 3'd3;
    localparam logic [2:0] BLANK = 3'd4;

    if (DATA_WIDTH != COLS * BPP) begin : g_bad_width
        $error("matrix_scan: DATA_WIDTH must equal COLS*BPP");
    end
    if (ROWS > 2 ** ADDR_WIDTH) begin : g_bad_addr
        $error("matrix_scan: ROWS does not fit in ADDR_WIDTH");
    end
    if (TICK_DIV < 1 || BLANK_CYCLES < 1) begin : g_bad_timing
        $error("matrix_scan: TICK_DIV and BLANK_CYCLES must be >= 1");
    end

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] row;
    logic [DATA_WIDTH-1:0] row_buf;
    logic [TW-1:0]         tick;
    logic [BPP-1:0]        pwm;
    logic [BW-1:0]         blank_cnt;

    logic                  tick_wrap;
    logic                  show_done;
    logic [BPP-1:0]        pwm_next;
    logic [ADDR_WIDTH-1:0] row_next;
    logic [DATA_WIDTH-1:0] pix_src;
    logic [BPP-1:0]        pix_lvl;
    logic [COLS-1:0]       col_next;

    assign tick_wrap = (tick == TICK_LAST);
    assign show_done = tick_wrap && (pwm == PWM_LAST);
    assign pwm_next  = tick_wrap ? pwm + BPP'(1) : pwm;
    assign row_next  = (row == ROW_LAST) ? '0 : row + ADDR_WIDTH'(1);

    // col_on is registered, so it is computed for the level of the coming
    // cycle. On the LATCH edge row_buf is still loading, so the fresh word
    // is taken straight from mem_rdata at level 0.
    always_comb begin
        pix_src  = (state == LATCH) ? mem.mem_rdata : row_buf;
        pix_lvl  = (state == LATCH) ? '0 : pwm_next;
        col_next = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            col_next[c] = (pix_src[c*BPP +: BPP] > pix_lvl);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            row          <= '0;
            row_buf      <= '0;
            tick         <= '0;
            pwm          <= '0;
            blank_cnt    <= '0;
            mem.mem_rd   <= 1'b0;
            mem.mem_addr <= '0;
            row_sel      <= '0;
            col_on       <= '0;
            frame_start  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            mem.mem_rd  <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state        <= FETCH;
                        mem.mem_rd   <= 1'b1;
                        mem.mem_addr <= '0;
                        frame_start  <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    row_buf <= mem.mem_rdata;
                    tick    <= '0;
                    pwm     <= '0;
                    row_sel <= ROWS'(1) << row;
                    col_on  <= col_next;
                    state   <= SHOW;
                end
                SHOW: begin
                    if (show_done) begin
                        state     <= BLANK;
                        tick      <= '0;
                        pwm       <= '0;
                        blank_cnt <= '0;
                        row_sel   <= '0;
                        col_on    <= '0;
                    end else begin
                        tick   <= tick_wrap ? '0 : tick + TW'(1);
                        pwm    <= pwm_next;
                        col_on <= col_next;
                    end
                end
                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        blank_cnt <= '0;
                        if (enable) begin
                            row          <= row_next;
                            state        <= FETCH;
                            mem.mem_rd   <= 1'b1;
                            mem.mem_addr <= row_next;
                            frame_start  <= (row_next == '0);
                        end else begin
                            row   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + BW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    row     <= '0;
                    row_sel <= '0;
                    col_on  <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
